// File: rtl/priority_encoder_pkg.sv
// Shared constants and width helper for the priority encoder slice.
package priority_encoder_pkg;

  localparam int unsigned PE_N_DEFAULT = 4;

  // Index width that never collapses to zero, so N=2 still yields a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// Combinational core: index, any-request flag and one-hot of the highest set request bit.
module priority_encoder_core
  import priority_encoder_pkg::*;
#(
  parameter int unsigned N  = PE_N_DEFAULT,
  parameter int unsigned AW = clog2_min1(N)
) (
  input  logic [N-1:0]  y,
  output logic [AW-1:0] idx,
  output logic          valid_c,
  output logic [N-1:0]  onehot_c
);

  // Scan from the top down and stop at the first set bit, so lower bits (even X) are ignored.
  always_comb begin
    idx      = '0;
    valid_c  = 1'b0;
    onehot_c = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid_c && (y[i] == 1'b1)) begin
        valid_c     = 1'b1;
        idx         = AW'(i);
        onehot_c[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/priority_encoder.sv
// N-input priority encoder with optional enable-gated output register.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int unsigned N       = PE_N_DEFAULT,
  parameter int unsigned AW      = clog2_min1(N),
  parameter bit          REG_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  y,
  output logic [AW-1:0] a,
  output logic          valid,
  output logic [N-1:0]  onehot
);

  logic [AW-1:0] idx;
  logic          valid_c;
  logic [N-1:0]  onehot_c;

  priority_encoder_core #(
    .N  (N),
    .AW (AW)
  ) u_core (
    .y        (y),
    .idx      (idx),
    .valid_c  (valid_c),
    .onehot_c (onehot_c)
  );

  if (REG_OUT) begin : g_reg
    logic [AW-1:0] a_d, a_q;
    logic          valid_d, valid_q;
    logic [N-1:0]  onehot_d, onehot_q;

    always_comb begin
      a_d      = a_q;
      valid_d  = valid_q;
      onehot_d = onehot_q;
      if (en) begin
        a_d      = idx;
        valid_d  = valid_c;
        onehot_d = onehot_c;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_q      <= '0;
        valid_q  <= 1'b0;
        onehot_q <= '0;
      end else begin
        a_q      <= a_d;
        valid_q  <= valid_d;
        onehot_q <= onehot_d;
      end
    end

    assign a      = a_q;
    assign valid  = valid_q;
    assign onehot = onehot_q;
  end else begin : g_comb
    // Clock, reset and enable are intentionally unused in the bypass build.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};

    assign a      = idx;
    assign valid  = valid_c;
    assign onehot = onehot_c;
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Self-checking bench: registered N=4 instance via scoreboard, combinational N=8 instance via table.
module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] y;
  logic [1:0] a;
  logic       valid;
  logic [3:0] onehot;

  logic [7:0] y8;
  logic [2:0] a8;
  logic       valid8;
  logic [7:0] onehot8;

  int checks = 0;
  int errors = 0;

  priority_encoder #(
    .N       (4),
    .REG_OUT (1'b1)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .y      (y),
    .a      (a),
    .valid  (valid),
    .onehot (onehot)
  );

  priority_encoder #(
    .N       (8),
    .REG_OUT (1'b0)
  ) u_comb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .y      (y8),
    .a      (a8),
    .valid  (valid8),
    .onehot (onehot8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] a;
    logic       v;
    logic [3:0] oh;
  } exp_t;

  typedef struct {
    logic [3:0] y;
    exp_t       e;
  } vec_t;

  typedef struct {
    logic [7:0] y;
    logic [2:0] a;
    logic       v;
    logic [7:0] oh;
  } vec8_t;

  exp_t sb_q[$];

  function automatic exp_t mk(input logic [1:0] ea, input logic ev, input logic [3:0] eoh);
    exp_t e;
    e.a  = ea;
    e.v  = ev;
    e.oh = eoh;
    return e;
  endfunction

  task automatic check_pop(input string name);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got a=%0d valid=%0b onehot=%b", name, a, valid, onehot);
    end else begin
      e = sb_q.pop_front();
      if ({a, valid, onehot} !== {e.a, e.v, e.oh}) begin
        errors++;
        $display("FAIL %s: got a=%0d valid=%0b onehot=%b, want a=%0d valid=%0b onehot=%b",
                 name, a, valid, onehot, e.a, e.v, e.oh);
      end
    end
  endtask

  // Drive on the falling edge, expect the result just after the next rising edge.
  task automatic cycle(input logic [3:0] yv, input logic ev, input logic rv, input exp_t e,
                       input string name);
    @(negedge clk);
    y     = yv;
    en    = ev;
    rst_n = rv;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    check_pop(name);
  endtask

  vec_t  vecs[];
  vec8_t vecs8[];

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    y     = 4'b0000;
    y8    = 8'h00;

    vecs = new[10];
    vecs[0] = '{4'b1000, mk(2'd3, 1'b1, 4'b1000)};
    vecs[1] = '{4'b0100, mk(2'd2, 1'b1, 4'b0100)};
    vecs[2] = '{4'b0010, mk(2'd1, 1'b1, 4'b0010)};
    vecs[3] = '{4'b0001, mk(2'd0, 1'b1, 4'b0001)};
    vecs[4] = '{4'b1011, mk(2'd3, 1'b1, 4'b1000)};
    vecs[5] = '{4'b0111, mk(2'd2, 1'b1, 4'b0100)};
    vecs[6] = '{4'b0011, mk(2'd1, 1'b1, 4'b0010)};
    vecs[7] = '{4'b1x1x, mk(2'd3, 1'b1, 4'b1000)};
    vecs[8] = '{4'b0000, mk(2'd0, 1'b0, 4'b0000)};
    vecs[9] = '{4'b0100, mk(2'd2, 1'b1, 4'b0100)};

    vecs8 = new[5];
    vecs8[0] = '{8'b0010_0101, 3'd5, 1'b1, 8'b0010_0000};
    vecs8[1] = '{8'b0000_0000, 3'd0, 1'b0, 8'b0000_0000};
    vecs8[2] = '{8'b1000_0001, 3'd7, 1'b1, 8'b1000_0000};
    vecs8[3] = '{8'b0000_0001, 3'd0, 1'b1, 8'b0000_0001};
    vecs8[4] = '{8'b0100_1111, 3'd6, 1'b1, 8'b0100_0000};

    // Reset held with all requests active, then first enabled edge after release.
    for (int i = 0; i < 3; i++) cycle(4'b1111, 1'b1, 1'b0, mk(2'd0, 1'b0, 4'b0000), "reset_hold");
    cycle(4'b1111, 1'b1, 1'b1, mk(2'd3, 1'b1, 4'b1000), "reset_release");

    for (int i = 0; i < 10; i++) cycle(vecs[i].y, 1'b1, 1'b1, vecs[i].e, $sformatf("vec%0d", i));

    // Enable low holds the captured value.
    cycle(4'b0010, 1'b1, 1'b1, mk(2'd1, 1'b1, 4'b0010), "hold_capture");
    for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b0, 1'b1, mk(2'd1, 1'b1, 4'b0010), "en_hold");

    // Asynchronous clear between edges.
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk(2'd0, 1'b0, 4'b0000));
    check_pop("async_reset");
    cycle(4'b1000, 1'b0, 1'b1, mk(2'd0, 1'b0, 4'b0000), "post_reset_en_low");
    cycle(4'b1000, 1'b1, 1'b1, mk(2'd3, 1'b1, 4'b1000), "post_reset_capture");

    // Combinational variant, with reset asserted to show it has no effect there.
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y8 = vecs8[i].y;
      #1;
      checks++;
      if ({a8, valid8, onehot8} !== {vecs8[i].a, vecs8[i].v, vecs8[i].oh}) begin
        errors++;
        $display("FAIL comb%0d: got a=%0d valid=%0b onehot=%b, want a=%0d valid=%0b onehot=%b",
                 i, a8, valid8, onehot8, vecs8[i].a, vecs8[i].v, vecs8[i].oh);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/priority_encoder.md
Name: priority_encoder

Overview:
- Parameterised N-input priority encoder with registered outputs. The highest-indexed asserted request wins.
- Default N=4 gives the 4-to-2 function: y[3] is highest priority and y[0] is lowest.
- Sits between request sources (interrupt, arbitration or status lines) and logic that needs a binary index of the most urgent request, plus a "some request present" flag.

Parameters:
- N, 4, number of request inputs; must be ≥2.
- AW, $clog2(N), width of the encoded index output. Derived; do not override.
- REG_OUT, 1, 1 = outputs registered (1-cycle latency); 0 = outputs purely combinational from y (clk/rst_n unused).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  sample enable; when low, registered outputs hold.
- y  input  N  request vector; y[N-1] is highest priority.
- a  output  AW  index of highest set bit of y; for N=4, a[1]=a1, a[0]=a0.
- valid  output  1  1 when any bit of y is set.
- onehot  output  N  one-hot of the winning bit; all-zero when no request.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. While rst_n=0: a=0, valid=0, onehot=0, regardless of clk or en.
- Combinational core:
  - idx = largest i with y[i]=1.
  - valid_c = |y.
  - onehot_c = (1<<idx) if valid_c, else 0.
  - If y=0, then idx=0 and valid_c=0. Consumers must qualify a with valid.
- Priority: lower bits are don't-care once a higher bit is set. For example, with N=4, y=4'b1xxx gives a=3; 4'b01xx gives a=2; 4'b001x gives a=1; 4'b0001 gives a=0.
- REG_OUT=1:
  - On rising clk with en=1: a<=idx, valid<=valid_c, onehot<=onehot_c.
  - With en=0: all outputs hold.
  - Latency is 1 cycle from y to outputs.
- REG_OUT=0: outputs equal the core outputs with zero latency. Reset has no effect.
- Reset deassertion: the first capture is at the first rising edge with rst_n=1 and en=1.
- Reset mid-operation: asserting rst_n clears outputs immediately and asynchronously, without waiting for a clock edge.
- Inputs are sampled only at the clock edge. Glitches between edges have no effect in REG_OUT=1.
- X on lower-priority bits must not corrupt a when a higher bit is 1. Implement as a descending-priority scan loop or casez, not arithmetic.

Decomposition:
- Package priority_encoder_pkg:
  - function clog2_min1(n), which returns ≥1 so that N=2 yields AW=1.
  - default constants PE_N_DEFAULT=4.
- Sub-module priority_encoder_core: purely combinational (y -> idx, valid_c, onehot_c), parameterised by N.
- Top level: instantiates the core and adds the enable-gated output register plus the REG_OUT generate bypass.

Test Plan:
- Reset: drive y=4'b1111 with rst_n=0 for 3 cycles, then release -> a=0, valid=0, onehot=0 during reset; after the first enabled edge, a=3, valid=1, onehot=4'b1000.
- Priority sweep (N=4, en=1): apply y=1000, 0100, 0010, 0001 over four cycles -> next cycle a=3, 2, 1, 0 respectively; valid=1 each time; onehot equal to the input.
- Don't-care bits: y=1011 -> a=3. y=0111 -> a=2. y=0011 -> a=1. Also drive lower bits to X with y[3]=1 -> a=3 with no X on a.
- No request: y=0000 -> a=0, valid=0, onehot=0000. Then y=0100 -> a=2, valid=1 one cycle later.
- Enable hold and async reset: capture y=0010 (a=1). Set en=0 and drive y=1000 for 3 cycles -> a stays 1. Pulse rst_n low between clock edges -> a, valid and onehot go to 0 immediately.
- Combinational variant (REG_OUT=0, N=8): y=8'b0010_0101 -> a=5, valid=1 in the same timestep. y=0 -> valid=0.
